// File: rtl/cla_adder_sched.sv
// Round-robin scheduler sharing one carry-in-less W-bit adder between NREQ requesters.
// Add takes one adder pass; subtract takes two (A + ~B, then +1).
module cla_adder_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 32,
  parameter int unsigned IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_sub,
  output logic [W-1:0]      add_a,
  output logic [W-1:0]      add_b,
  input  logic [W-1:0]      add_s,
  input  logic              add_cout,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_sum,
  output logic              rsp_cout,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, PASS1, PASS2, RESP} state_t;

  state_t          state, state_d;
  logic [IDW-1:0]  ptr, ptr_d;
  logic [IDW-1:0]  grant, idx;
  logic            grant_vld;
  logic            sub_q, sub_d;
  logic            c1_q, c1_d;
  logic [W-1:0]    sel_a, sel_b;
  logic            sel_sub;
  logic [W-1:0]    add_a_d, add_b_d, rsp_sum_d;
  logic [IDW-1:0]  rsp_id_d;
  logic            rsp_cout_d, rsp_valid_d, busy_d;

  // Round-robin search starting one past the last accepted requester
  always_comb begin
    grant     = ptr;
    grant_vld = 1'b0;
    idx       = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = IDW'((32'(ptr) + k) % NREQ);
      if (!grant_vld && req_valid[idx]) begin
        grant     = idx;
        grant_vld = 1'b1;
      end
    end
  end

  // Operand select for the granted requester
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_sub = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant == IDW'(i)) begin
        sel_a   = req_a[i*W +: W];
        sel_b   = req_b[i*W +: W];
        sel_sub = req_sub[i];
      end
    end
  end

  // Ready is combinational so the handshake lands in the same cycle as valid
  always_comb begin
    req_ready = '0;
    if (rst_n && state == IDLE && grant_vld)
      req_ready = NREQ'(1) << grant;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= IDW'(NREQ - 1);
      sub_q     <= 1'b0;
      c1_q      <= 1'b0;
      add_a     <= '0;
      add_b     <= '0;
      rsp_sum   <= '0;
      rsp_id    <= '0;
      rsp_cout  <= 1'b0;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      sub_q     <= sub_d;
      c1_q      <= c1_d;
      add_a     <= add_a_d;
      add_b     <= add_b_d;
      rsp_sum   <= rsp_sum_d;
      rsp_id    <= rsp_id_d;
      rsp_cout  <= rsp_cout_d;
      rsp_valid <= rsp_valid_d;
      busy      <= busy_d;
    end
  end

  // Next state and next register values
  always_comb begin
    state_d    = state;
    ptr_d      = ptr;
    sub_d      = sub_q;
    c1_d       = c1_q;
    add_a_d    = add_a;
    add_b_d    = add_b;
    rsp_sum_d  = rsp_sum;
    rsp_id_d   = rsp_id;
    rsp_cout_d = rsp_cout;
    unique case (state)
      IDLE: begin
        if (grant_vld) begin
          state_d  = PASS1;
          ptr_d    = grant;
          rsp_id_d = grant;
          sub_d    = sel_sub;
          add_a_d  = sel_a;
          add_b_d  = sel_sub ? ~sel_b : sel_b;
        end
      end
      PASS1: begin
        if (sub_q) begin
          // Second pass supplies the missing carry-in of the two's complement
          add_a_d = add_s;
          add_b_d = W'(1);
          c1_d    = add_cout;
          state_d = PASS2;
        end else begin
          rsp_sum_d  = add_s;
          rsp_cout_d = add_cout;
          state_d    = RESP;
        end
      end
      PASS2: begin
        rsp_sum_d  = add_s;
        rsp_cout_d = c1_q | add_cout;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rsp_valid_d = (state_d == RESP);
    busy_d      = (state_d != IDLE);
  end

endmodule

// File: tb/tb_cla_adder_sched.sv
// Self-checking bench for cla_adder_sched: vector table, scoreboard monitor and
// hand-written sequences for round-robin, backpressure and mid-op reset.
module tb_cla_adder_sched;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int IDW  = 2;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_sub;
  logic [W-1:0]      add_a;
  logic [W-1:0]      add_b;
  logic [W-1:0]      add_s;
  logic              add_cout;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_sum;
  logic              rsp_cout;
  logic              busy;

  cla_adder_sched #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
    .add_a(add_a), .add_b(add_b), .add_s(add_s), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .busy(busy)
  );

  // Shared combinational adder, no carry-in
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] sum;
    logic        cout;
    int          lat;
  } vec_t;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] sum;
    logic        cout;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input int id, input logic [31:0] a, input logic [31:0] b,
                                 input logic sub);
    exp_t e;
    e.id = 2'(id);
    if (sub) begin
      e.sum  = a - b;
      e.cout = (a >= b);
    end else begin
      {e.cout, e.sum} = {1'b0, a} + {1'b0, b};
    end
    return e;
  endfunction

  // Scoreboard: push on accept, pop and compare on response handshake
  always @(negedge clk) begin
    if (rst_n) begin
      if (|(req_valid & req_ready)) begin
        chk("grant_onehot", 64'($countones(req_ready)), 64'd1);
        for (int i = 0; i < NREQ; i++) begin
          if (req_valid[2'(i)] && req_ready[2'(i)]) begin
            sb.push_back(model(i, req_a[7'(i*W) +: W], req_b[7'(i*W) +: W], req_sub[2'(i)]));
            grant_log.push_back(i);
          end
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_rsp", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_sum", 64'(rsp_sum), 64'(e.sum));
          chk("sb_cout", 64'(rsp_cout), 64'(e.cout));
          chk("sb_id", 64'(rsp_id), 64'(e.id));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic sub);
    for (int i = 0; i < NREQ; i++) begin
      if (i == id) begin
        req_a[7'(i*W) +: W] = a;
        req_b[7'(i*W) +: W] = b;
        req_sub[2'(i)]      = sub;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_accept(input int id, output int t0);
    bit got = 1'b0;
    t0 = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (req_ready[2'(id)] && req_valid[2'(id)]) begin
        got = 1'b1;
        t0  = cyc;
      end
    end
    chk("accept_seen", 64'(got), 64'd1);
  endtask

  task automatic wait_rsp(output int t1);
    bit got = 1'b0;
    t1 = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1;
        t1  = cyc;
      end
    end
    chk("rsp_seen", 64'(got), 64'd1);
  endtask

  task automatic wait_idle();
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (!busy && !rsp_valid) got = 1'b1;
    end
    chk("idle_seen", 64'(got), 64'd1);
  endtask

  task automatic do_op(input vec_t v);
    int t0, t1;
    @(posedge clk); #1;
    set_req(v.id, v.a, v.b, v.sub);
    req_valid = '0;
    req_valid[2'(v.id)] = 1'b1;
    wait_accept(v.id, t0);
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp(t1);
    chk("latency", 64'(t1 - t0), 64'(v.lat));
    chk("vec_sum", 64'(rsp_sum), 64'(v.sum));
    chk("vec_cout", 64'(rsp_cout), 64'(v.cout));
    chk("vec_id", 64'(rsp_id), 64'(v.id));
  endtask

  vec_t vecs[8];

  initial begin
    int t0, t1;
    vecs[0] = '{0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 2};
    vecs[1] = '{2, 32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0002, 1'b1, 3};
    vecs[2] = '{2, 32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 3};
    vecs[3] = '{2, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 3};
    vecs[4] = '{1, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 2};
    vecs[5] = '{3, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 2};
    vecs[6] = '{3, 32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 3};
    vecs[7] = '{1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b1, 3};

    rst_n     = 1'b0;
    req_valid = '1;
    req_a     = {$urandom, $urandom, $urandom, $urandom};
    req_b     = {$urandom, $urandom, $urandom, $urandom};
    req_sub   = '0;
    rsp_ready = 1'b1;

    // Reset values, with every requester asking
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_add_a", 64'(add_a), 64'd0);
    chk("rst_add_b", 64'(add_b), 64'd0);
    chk("rst_rsp_sum", 64'(rsp_sum), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_cout", 64'(rsp_cout), 64'd0);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    req_valid = '0;

    for (int i = 0; i < 8; i++) do_op(vecs[i]);
    wait_idle();

    // Round-robin with all requesters continuously valid from reset
    do_reset();
    grant_log.delete();
    for (int i = 0; i < NREQ; i++)
      set_req(i, 32'(i * 16 + 1), 32'(i + 2), i[0]);
    req_valid = '1;
    for (int i = 0; i < 60 && grant_log.size() < 5; i++) @(negedge clk);
    @(posedge clk); #1;
    req_valid = '0;
    chk("rr_count", 64'(grant_log.size() >= 5), 64'd1);
    if (grant_log.size() >= 5) begin
      chk("rr_grant0", 64'(grant_log[0]), 64'd0);
      chk("rr_grant1", 64'(grant_log[1]), 64'd1);
      chk("rr_grant2", 64'(grant_log[2]), 64'd2);
      chk("rr_grant3", 64'(grant_log[3]), 64'd3);
      chk("rr_grant4", 64'(grant_log[4]), 64'd0);
    end
    wait_idle();

    // Backpressure: stall in RESP while another requester waits
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    set_req(0, 32'd7, 32'd8, 1'b0);
    set_req(1, 32'd1, 32'd2, 1'b0);
    req_valid = 4'b0001;
    wait_accept(0, t0);
    @(posedge clk); #1;
    req_valid = 4'b0010;
    wait_rsp(t1);
    chk("bp_latency", 64'(t1 - t0), 64'd2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_rsp_sum", 64'(rsp_sum), 64'h0000_000F);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_hold_valid", 64'(rsp_valid), 64'd1);
    @(negedge clk);
    chk("bp_resume_ready", 64'(req_ready), 64'b0010);
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle();

    // Mid-op reset during PASS2 of a subtract
    @(posedge clk); #1;
    set_req(2, 32'd9, 32'd4, 1'b1);
    set_req(0, 32'd100, 32'd23, 1'b0);
    req_valid = 4'b0100;
    wait_accept(2, t0);
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    chk("mr_busy_before", 64'(busy), 64'd1);
    chk("mr_pass2_add_b", 64'(add_b), 64'd1);
    req_valid = 4'b0101;
    rst_n = 1'b0;
    #1;
    chk("mr_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_req_ready", 64'(req_ready), 64'd0);
    chk("mr_add_a", 64'(add_a), 64'd0);
    sb.delete();
    grant_log.delete();
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_accept(0, t0);
    @(posedge clk); #1;
    req_valid = '0;
    chk("mr_first_grant", 64'(grant_log.size() > 0 ? grant_log[0] : 99), 64'd0);
    wait_rsp(t1);
    chk("mr_latency", 64'(t1 - t0), 64'd2);
    chk("mr_sum", 64'(rsp_sum), 64'd123);
    chk("mr_id", 64'(rsp_id), 64'd0);
    wait_idle();

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cla_adder_sched.md
# cla_adder_sched

Round-robin scheduler that shares one combinational 32-bit carry-lookahead adder between NREQ requesters. The shared adder has no carry-in, so the block sequences it:
- add: one pass.
- subtract: two passes, A + ~B and then +1.

It sits between the requesting pipeline units and the single adder instance, and returns each result with the ID of the requester that issued it.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 32, operand width; must match the shared adder.
- IDW, 2, requester-ID width; equals clog2(NREQ).

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept, one-hot or zero.
- req_a  in  NREQ*W  operand A; requester i owns slice [i*W +: W].
- req_b  in  NREQ*W  operand B, same slicing.
- req_sub  in  NREQ  1 = A−B, 0 = A+B.
- add_a  out  W  registered operand A to the shared adder.
- add_b  out  W  registered operand B to the shared adder.
- add_s  in  W  adder sum, combinational from add_a/add_b.
- add_cout  in  1  adder carry-out.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  IDW  index of the requester that issued the op.
- rsp_sum  out  W  result.
- rsp_cout  out  1  add: carry-out; sub: 1 = no borrow (A ≥ B unsigned).
- busy  out  1  high in any state other than IDLE.

## Operation
FSM states are IDLE, PASS1, PASS2, RESP.

- IDLE
  - Round-robin grant: search starts at ptr+1 mod NREQ and picks the first i with req_valid[i].
  - req_ready[grant] = 1. All other req_ready bits are 0.
  - On handshake:
    - latch the requester ID and the sub flag;
    - load add_a = A and add_b = sub ? ~B : B;
    - set ptr = grant;
    - go to PASS1.
- PASS1
  - The adder evaluates the loaded operands.
  - At the end of the cycle, latch s1 = add_s and c1 = add_cout.
  - Add: rsp_sum = s1, rsp_cout = c1, go to RESP.
  - Sub: load add_a = s1 and add_b = 1, go to PASS2.
- PASS2
  - Latch rsp_sum = add_s and rsp_cout = c1 | add_cout.
  - Go to RESP.
- RESP
  - rsp_valid = 1. rsp_id, rsp_sum and rsp_cout are held stable until rsp_ready.
  - On rsp_valid & rsp_ready, go to IDLE.
  - No new request is accepted in RESP.

Arithmetic and grant rules:
- All arithmetic is modulo 2^W. Signed overflow is not reported.
- ptr resets to NREQ−1, so requester 0 has first priority after reset.
- ptr changes only on an accepted request.

## Timing
Reset values (rst_n low):
- state = IDLE; ptr = NREQ−1.
- add_a, add_b, rsp_sum, rsp_id = 0; rsp_cout, rsp_valid, busy = 0.
- req_ready is forced to 0 while rst_n is low.

Ready and handshake:
- req_ready is combinational from req_valid and the state. It is valid in the same cycle as req_valid.
- The handshake happens in cycle T when req_valid[i] & req_ready[i].

Latency and throughput:
- Add: rsp_valid first high in cycle T+2.
- Sub: rsp_valid first high in cycle T+3.
- rsp_ready is high on the first valid cycle in both cases.
- Back-to-back throughput: an add occupies the adder 3 cycles and a sub 4 cycles per op. The next accept is in the cycle after the response handshake.

Adder timing:
- The adder is combinational. add_s and add_cout are sampled in the same cycle that add_a/add_b are stable.
- add_a and add_b change only on the IDLE→PASS1 and PASS1→PASS2 transitions.

Boundary conditions:
- A requester that drops req_valid before the handshake is not served and ptr is unchanged.
- Requesters that are valid while busy wait. They are not lost.
- rsp_ready held low stalls the block in RESP indefinitely with the response outputs stable.
- Asserting rst_n mid-operation aborts the op immediately. There is no response for it and every output goes to its reset value.

## Test plan
- Single add: req0 drives A=0xFFFFFFFF, B=0x00000001, sub=0; rsp_ready=1 → handshake at T, rsp_valid at T+2 with sum=0x00000000, cout=1, id=0.
- Subtract cases on req2 (sub=1), each checking that rsp_valid rises at T+3:
  - 5−3 → sum=0x00000002, cout=1.
  - 3−5 → sum=0xFFFFFFFE, cout=0.
  - 0−0 → sum=0x00000000, cout=1.
- Round-robin: all four requesters valid continuously after reset → grant order 0,1,2,3,0. Exactly one req_ready bit high in each accept cycle.
- Backpressure: rsp_ready=0 for 10 cycles after an add 7+8 → rsp_valid held with sum=0x0000000F and no req_ready during the stall. Accept resumes the cycle after rsp_ready=1.
- Mid-op reset: pull rst_n low during PASS2 of a sub → rsp_valid, busy and req_ready go to 0 asynchronously. After release, the first request is served with req0 priority and the correct result.
